// File: rtl/game_pkg.sv
// Shared cell/result codes and FSM state encoding for the N x N tic-tac-toe block.
package game_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_PLAYER = 2'b01;
  localparam logic [1:0] CELL_COMP   = 2'b10;

  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_PLAYER = 2'b01;
  localparam logic [1:0] WHO_COMP   = 2'b10;
  localparam logic [1:0] WHO_DRAW   = 2'b11;

  typedef enum logic [2:0] {
    P_TURN,
    P_CHECK,
    C_TURN,
    C_CHECK,
    DONE
  } game_state_t;

endpackage

// File: rtl/line_win_detector.sv
// Combinational K-in-a-row detector over every horizontal, vertical, diagonal and
// anti-diagonal window of an N x N board; zero latency, no flow control.
module line_win_detector #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic [2*N*N-1:0] board,
  input  logic [1:0]       mark,
  output logic             win
);

  // One hit bit per (start cell, direction); directions: 0 row, 1 column, 2 diag, 3 anti-diag.
  logic [4*N*N-1:0] hit;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      for (genvar d = 0; d < 4; d++) begin : g_dir
        localparam int DR = (d == 0) ? 0 : 1;
        localparam int DC = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
        localparam int ER = r + DR * (K - 1);
        localparam int EC = c + DC * (K - 1);
        if (ER < N && EC >= 0 && EC < N) begin : g_win
          logic [K-1:0] m;
          for (genvar k = 0; k < K; k++) begin : g_k
            assign m[k] = (board[2*((r + DR*k)*N + c + DC*k) +: 2] == mark);
          end
          assign hit[4*(r*N + c) + d] = &m;
        end else begin : g_none
          assign hit[4*(r*N + c) + d] = 1'b0;
        end
      end
    end
  end

  assign win = |hit;

endmodule

// File: rtl/nxn_tic_tac_toe_game.sv
// N x N, K-in-a-row player-vs-computer game: board written on the accepting edge, result one cycle later.
// Strobes off-turn or outside TURN states are dropped; TURN_TIMER_EN adds a per-turn forfeit timer.
module nxn_tic_tac_toe_game
  import game_pkg::*;
#(
  parameter int N       = 3,
  parameter int K       = 3,
  parameter int POS_W   = $clog2(N*N),
  parameter int TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               play,
  input  logic               pc,
  input  logic [POS_W-1:0]   player_position,
  input  logic [POS_W-1:0]   computer_position,
  output logic [2*N*N-1:0]   board,
  output logic               turn,
  output logic               illegal,
  output logic               game_over,
  output logic [1:0]         who
);

  localparam int CELLS = N * N;

  game_state_t          state_q, state_d;
  logic [2*CELLS-1:0]   board_q, board_d;
  logic                 illegal_q, illegal_d;
  logic [1:0]           who_q, who_d;
  logic                 over_q, over_d;
  logic [1:0]           chk_mark;
  logic                 win, full;
  logic                 tmo;

  function automatic logic move_ok(input logic [POS_W-1:0] pos, input logic [2*CELLS-1:0] b);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < CELLS; i++)
      if (int'(pos) == i && b[2*i +: 2] == CELL_EMPTY) ok = 1'b1;
    return ok;
  endfunction

  function automatic logic [2*CELLS-1:0] place(input logic [2*CELLS-1:0] b,
                                               input logic [POS_W-1:0] pos,
                                               input logic [1:0] mark);
    logic [2*CELLS-1:0] r;
    r = b;
    for (int i = 0; i < CELLS; i++)
      if (int'(pos) == i) r[2*i +: 2] = mark;
    return r;
  endfunction

  assign chk_mark = (state_q == C_CHECK) ? CELL_COMP : CELL_PLAYER;

  line_win_detector #(.N(N), .K(K)) u_win (
    .board (board_q),
    .mark  (chk_mark),
    .win   (win)
  );

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < CELLS; i++)
      if (board_q[2*i +: 2] == CELL_EMPTY) full = 1'b0;
  end

`ifdef TURN_TIMER_EN
  localparam int TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TMR_W-1:0] timer_q;

  // Fires on the TIMEOUT-th cycle spent in a turn state, so the forfeit lands at that edge.
  assign tmo = (timer_q == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset)
      timer_q <= '0;
    else if ((state_q == P_TURN || state_q == C_TURN) && state_d == state_q)
      timer_q <= timer_q + 1'b1;
    else
      timer_q <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    illegal_d = 1'b0;
    who_d     = who_q;
    over_d    = over_q;
    unique case (state_q)
      P_TURN: begin
        if (play && move_ok(player_position, board_q)) begin
          board_d = place(board_q, player_position, CELL_PLAYER);
          state_d = P_CHECK;
        end else begin
          illegal_d = play;
          if (tmo) begin
            who_d   = WHO_COMP;
            over_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      C_TURN: begin
        if (pc && move_ok(computer_position, board_q)) begin
          board_d = place(board_q, computer_position, CELL_COMP);
          state_d = C_CHECK;
        end else begin
          illegal_d = pc;
          if (tmo) begin
            who_d   = WHO_PLAYER;
            over_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      P_CHECK, C_CHECK: begin
        // A line completed by the last free cell is a win, so win is tested before full.
        if (win) begin
          who_d   = (state_q == P_CHECK) ? WHO_PLAYER : WHO_COMP;
          over_d  = 1'b1;
          state_d = DONE;
        end else if (full) begin
          who_d   = WHO_DRAW;
          over_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = (state_q == P_CHECK) ? C_TURN : P_TURN;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = P_TURN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= P_TURN;
      board_q   <= '0;
      illegal_q <= 1'b0;
      who_q     <= WHO_NONE;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      illegal_q <= illegal_d;
      who_q     <= who_d;
      over_q    <= over_d;
    end
  end

  assign board     = board_q;
  assign turn      = (state_q == C_TURN) || (state_q == C_CHECK);
  assign illegal   = illegal_q;
  assign game_over = over_q;
  assign who       = who_q;

endmodule

// File: tb/tb_nxn_tic_tac_toe_game.sv
// Bench for nxn_tic_tac_toe_game: 3x3 vector table with a scoreboard queue, plus 5x5/K=4 and timer sequences.
module tb_nxn_tic_tac_toe_game;
  import game_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 3x3 instance
  logic        reset3, play3, pc3;
  logic [3:0]  ppos3, cpos3;
  logic [17:0] board3;
  logic        turn3, ill3, over3;
  logic [1:0]  who3;

  nxn_tic_tac_toe_game #(.N(3), .K(3), .TIMEOUT(10)) dut3 (
    .clock(clock), .reset(reset3), .play(play3), .pc(pc3),
    .player_position(ppos3), .computer_position(cpos3),
    .board(board3), .turn(turn3), .illegal(ill3), .game_over(over3), .who(who3)
  );

  // 5x5, K=4 instance
  logic        reset5, play5, pc5;
  logic [4:0]  ppos5, cpos5;
  logic [49:0] board5;
  logic        turn5, ill5, over5;
  logic [1:0]  who5;

  nxn_tic_tac_toe_game #(.N(5), .K(4)) dut5 (
    .clock(clock), .reset(reset5), .play(play5), .pc(pc5),
    .player_position(ppos5), .computer_position(cpos5),
    .board(board5), .turn(turn5), .illegal(ill5), .game_over(over5), .who(who5)
  );

  typedef struct {
    logic       rst, play, pc;
    logic [3:0] ppos, cpos;
    int         acc_pos;
    logic [1:0] acc_mark;
    logic       turn, ill;
    logic [1:0] who;
    logic       over;
  } vec_t;

  typedef struct {
    logic [17:0] board;
    logic        turn, ill;
    logic [1:0]  who;
    logic        over;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  task automatic add(input logic rst, input logic p, input logic c, input logic [3:0] pp,
                     input logic [3:0] cp, input int apos, input logic [1:0] amark,
                     input logic t, input logic il, input logic [1:0] w, input logic ov);
    vec_t v;
    v.rst = rst; v.play = p; v.pc = c; v.ppos = pp; v.cpos = cp;
    v.acc_pos = apos; v.acc_mark = amark; v.turn = t; v.ill = il; v.who = w; v.over = ov;
    tbl.push_back(v);
  endtask

  // Accepted move, then the CHECK cycle that hands the turn over.
  task automatic mv(input logic p, input int pos);
    logic [3:0] ps;
    ps = 4'(pos);
    add(0, p, !p, ps, ps, pos, p ? CELL_PLAYER : CELL_COMP, !p, 0, WHO_NONE, 0);
    add(0, 0, 0, 0, 0, 0, CELL_EMPTY, p, 0, WHO_NONE, 0);
  endtask

  // Final accepted move, then the CHECK cycle that ends the game.
  task automatic mv_end(input logic p, input int pos, input logic [1:0] w);
    logic [3:0] ps;
    ps = 4'(pos);
    add(0, p, !p, ps, ps, pos, p ? CELL_PLAYER : CELL_COMP, !p, 0, WHO_NONE, 0);
    add(0, 0, 0, 0, 0, 0, CELL_EMPTY, 0, 0, w, 1);
  endtask

  task automatic rst_row();
    add(1, 0, 0, 0, 0, 0, CELL_EMPTY, 0, 0, WHO_NONE, 0);
  endtask

  task automatic mv5(input logic p, input int pos);
    play5 = p; pc5 = !p; ppos5 = 5'(pos); cpos5 = 5'(pos);
    @(posedge clock); #1;
    play5 = 0; pc5 = 0;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [17:0] mb;
    exp_t e;
    vec_t v;

    // Game A: player wins on the top row, later strobes ignored.
    rst_row();
    mv(1, 0); mv(0, 4); mv(1, 1); mv(0, 5); mv_end(1, 2, WHO_PLAYER);
    add(0, 1, 0, 6, 0, 0, CELL_EMPTY, 0, 0, WHO_PLAYER, 1);
    add(0, 0, 1, 0, 7, 0, CELL_EMPTY, 0, 0, WHO_PLAYER, 1);
    // Game B: illegal moves, off-turn strobes, simultaneous strobes, reset in C_CHECK.
    rst_row();
    mv(1, 0); mv(0, 4);
    add(0, 1, 0, 4, 0, 0, CELL_EMPTY, 0, 1, WHO_NONE, 0);
    add(0, 0, 0, 0, 0, 0, CELL_EMPTY, 0, 0, WHO_NONE, 0);
    add(0, 1, 0, 9, 0, 0, CELL_EMPTY, 0, 1, WHO_NONE, 0);
    add(0, 0, 0, 0, 0, 0, CELL_EMPTY, 0, 0, WHO_NONE, 0);
    add(0, 0, 1, 0, 8, 0, CELL_EMPTY, 0, 0, WHO_NONE, 0);
    add(0, 1, 1, 1, 2, 1, CELL_PLAYER, 0, 0, WHO_NONE, 0);
    add(0, 1, 0, 3, 0, 0, CELL_EMPTY, 1, 0, WHO_NONE, 0);
    add(0, 0, 1, 0, 2, 2, CELL_COMP, 1, 0, WHO_NONE, 0);
    add(1, 1, 0, 3, 0, 0, CELL_EMPTY, 0, 0, WHO_NONE, 0);
    mv(1, 3);
    // Game C: drawn board.
    rst_row();
    mv(1, 0); mv(0, 1); mv(1, 2); mv(0, 4); mv(1, 3); mv(0, 5); mv(1, 7); mv(0, 6);
    mv_end(1, 8, WHO_DRAW);
    // Game D: the ninth move fills the board and completes the bottom row.
    rst_row();
    mv(1, 0); mv(0, 1); mv(1, 5); mv(0, 2); mv(1, 6); mv(0, 3); mv(1, 7); mv(0, 4);
    mv_end(1, 8, WHO_PLAYER);

    reset3 = 1; play3 = 0; pc3 = 0; ppos3 = 0; cpos3 = 0;
    reset5 = 1; play5 = 0; pc5 = 0; ppos5 = 0; cpos5 = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset board", 64'(board3), 64'd0);
    chk("reset turn", 64'(turn3), 64'd0);
    chk("reset illegal", 64'(ill3), 64'd0);
    chk("reset who", 64'(who3), 64'(WHO_NONE));
    chk("reset game_over", 64'(over3), 64'd0);
    reset5 = 0;

    mb = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      reset3 = v.rst; play3 = v.play; pc3 = v.pc; ppos3 = v.ppos; cpos3 = v.cpos;
      if (v.rst) mb = '0;
      else if (v.acc_mark != CELL_EMPTY) mb[2*v.acc_pos +: 2] = v.acc_mark;
      e.board = mb; e.turn = v.turn; e.ill = v.ill; e.who = v.who; e.over = v.over;
      sbq.push_back(e);
      @(posedge clock); #1;
      e = sbq.pop_front();
      chk($sformatf("row%0d board", i), 64'(board3), 64'(e.board));
      chk($sformatf("row%0d illegal", i), 64'(ill3), 64'(e.ill));
      chk($sformatf("row%0d who", i), 64'(who3), 64'(e.who));
      chk($sformatf("row%0d game_over", i), 64'(over3), 64'(e.over));
      if (!e.over) chk($sformatf("row%0d turn", i), 64'(turn3), 64'(e.turn));
    end
    reset3 = 0; play3 = 0; pc3 = 0;

    // 5x5, K=4: computer anti-diagonal 3,7,11,15 against scattered player moves.
    mv5(1, 20); chk("n5 turn after p20", 64'(turn5), 64'd1);
    mv5(0, 3);  chk("n5 turn after c3", 64'(turn5), 64'd0);
    mv5(1, 21); mv5(0, 7);
    mv5(1, 22); mv5(0, 11);
    mv5(1, 24);
    chk("n5 who before win", 64'(who5), 64'(WHO_NONE));
    chk("n5 turn before win", 64'(turn5), 64'd1);
    mv5(0, 15);
    chk("n5 who", 64'(who5), 64'(WHO_COMP));
    chk("n5 game_over", 64'(over5), 64'd1);
    chk("n5 cell15", 64'(board5[31:30]), 64'(CELL_COMP));
    chk("n5 cell24", 64'(board5[49:48]), 64'(CELL_PLAYER));
    chk("n5 illegal", 64'(ill5), 64'd0);

`ifdef TURN_TIMER_EN
    // No move for ten P_TURN cycles forfeits to the computer.
    reset3 = 1; @(posedge clock); #1; reset3 = 0;
    repeat (9) @(posedge clock);
    #1;
    chk("tmo who at 9", 64'(who3), 64'(WHO_NONE));
    @(posedge clock); #1;
    chk("tmo who at 10", 64'(who3), 64'(WHO_COMP));
    chk("tmo game_over", 64'(over3), 64'd1);
    // A legal move on the tenth cycle beats the timeout.
    reset3 = 1; @(posedge clock); #1; reset3 = 0;
    repeat (9) @(posedge clock);
    #1;
    play3 = 1; ppos3 = 4;
    @(posedge clock); #1;
    play3 = 0;
    chk("tmo move cell4", 64'(board3[9:8]), 64'(CELL_PLAYER));
    chk("tmo move who", 64'(who3), 64'(WHO_NONE));
    @(posedge clock); #1;
    chk("tmo move turn", 64'(turn3), 64'd1);
    chk("tmo move game_over", 64'(over3), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/nxn_tic_tac_toe_game.md
Name: nxn_tic_tac_toe_game

Overview:
- Parametrised successor of the 3x3 game: N x N board, K-in-a-row win rule, player-vs-computer turn sequencing.
- Holds the board registers, validates moves, alternates turns, and detects a win or draw after every accepted move.
- Sits between the move sources (player keypad and the computer move generator) and the board display logic.

Parameters:
- N, 3, board side length; 3..8.
- K, 3, marks in a row needed to win (row, column, either diagonal); 3..N.
- POS_W, $clog2(N*N), width of the position index.
- TIMEOUT, 255, turn-timer limit in cycles; used only with TURN_TIMER_EN.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clears the board and FSM.
- play  in  1  player move strobe, one cycle.
- pc  in  1  computer move strobe, one cycle.
- player_position  in  POS_W  player cell index, row-major; 0 is top-left.
- computer_position  in  POS_W  computer cell index, row-major.
- board  out  2*N*N  cell i is bits [2i+1:2i]; 00 empty, 01 player, 10 computer.
- turn  out  1  0 = player to move, 1 = computer to move.
- illegal  out  1  one-cycle pulse when a strobed move is rejected.
- game_over  out  1  high from game end until reset.
- who  out  2  00 none, 01 player won, 10 computer won, 11 draw.

Behaviour:
- Reset, taken on a clock edge while reset is high: board all zero, state P_TURN, turn=0, illegal=0, game_over=0, who=00.
- Reset is honoured in any state, including mid-CHECK, and overrides same-cycle strobes.
- FSM states: P_TURN, P_CHECK, C_TURN, C_CHECK, DONE.
- P_TURN, play=1, move legal: write 01 to the cell at that edge, go to P_CHECK.
- P_TURN, play=1, move illegal: illegal=1 for the next cycle, board unchanged, stay in P_TURN.
- A move is illegal if its index is >= N*N or the target cell is nonzero.
- P_CHECK, one cycle: evaluate the updated board.
  - Player K-in-a-row: who=01, game_over=1, go to DONE.
  - Otherwise, no empty cell: who=11, go to DONE.
  - Otherwise: go to C_TURN with turn=1.
  - A win on the final cell is a win, not a draw.
- C_TURN and C_CHECK mirror P_TURN and P_CHECK, using pc, computer_position, mark 10 and who=10.
- Strobe for the side not on turn: ignored, no illegal pulse. Both strobes together: only the on-turn strobe counts.
- Strobes in a CHECK state or in DONE are ignored.
- DONE: board frozen; who and game_over held until reset.
- Latency: board updates at the accepting edge; who and game_over are valid 1 cycle later (registered at the CHECK-to-DONE edge).
- Move-to-next-turn: 2 cycles minimum.
- Win check covers every length-K window: horizontal, vertical, diagonal and anti-diagonal, for the mark just placed.

Optional Feature:
- Macro: TURN_TIMER_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to P_TURN or C_TURN and increments each cycle in those states.
  - When it reaches TIMEOUT, the side to move forfeits: who = opponent code, game_over=1, go to DONE.
  - A legal move on the same cycle as the timeout wins over the timeout.
- Undefined: no counter; turns wait indefinitely.

Decomposition:
- Package game_pkg:
  - cell codes CELL_EMPTY, CELL_PLAYER, CELL_COMP;
  - who codes WHO_NONE, WHO_PLAYER, WHO_COMP, WHO_DRAW;
  - state enum game_state_t.
- Sub-module line_win_detector #(N,K): inputs board and 2-bit mark; output win. Pure combinational generate loops over all windows. Instantiated once, with the mark selected by state.

Test Plan:
- N=3,K=3: player 0,1,2; computer 4,5 -> who=01 and game_over one cycle after the third player move; later strobes ignored.
- N=3: computer plays 4 after player 0; player then plays 4 -> illegal pulse, cell 4 stays 10, turn stays 0; player 9 -> illegal pulse.
- N=3: fill the board in a drawn sequence -> who=11 after move 9; the variant whose last move completes a line -> who=01, not 11.
- N=5,K=4: computer anti-diagonal 3,7,11,15 with non-blocking player moves -> who=10.
- play and pc together during P_TURN -> only the player mark is written; reset asserted during C_CHECK -> board zero and P_TURN next cycle.
- TURN_TIMER_EN, TIMEOUT=10: no strobe in P_TURN -> who=10, game_over=1 after 10 cycles; legal move on cycle 10 -> accepted, no forfeit.
